// File: rtl/gon_bus_pkg.sv
// Shared definitions for the global output network bus: default widths,
// width consistency check and slave slice helpers.
package gon_bus_pkg;

  localparam int unsigned ID_BW_DEF    = 4;
  localparam int unsigned PKT_IN_DEF   = 8;
  localparam int unsigned PKT_OUT_DEF  = 12;
  localparam int unsigned SLV_NUM_DEF  = 6;

  // The master packet is exactly {tag, payload}; nothing else fits the format.
  function automatic bit widths_consistent(input int unsigned id_bw,
                                           input int unsigned pkt_in,
                                           input int unsigned pkt_out);
    return pkt_out == id_bw + pkt_in;
  endfunction

  // Low bit of slave k's slice in a flattened per-slave bus of width w.
  function automatic int unsigned slice_lo(input int unsigned k,
                                           input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/gon_bus_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr (mod N) wins; grant is
// one-hot with its encoded index alongside.
module rr_arbiter #(
  parameter int unsigned N  = 6,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned j = 0; j < N; j++) begin
      pos = 32'(ptr) + j;
      if (pos >= N) pos = pos - N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/gon_bus.sv
// Global output network bus: round-robin gathers slave packets onto one
// master link, tagging each with the producing slave's configured ID.
module gon_bus
  import gon_bus_pkg::*;
#(
  parameter int unsigned ID_BITWIDTH         = ID_BW_DEF,
  parameter int unsigned PACKET_IN_BITWIDTH  = PKT_IN_DEF,
  parameter int unsigned PACKET_OUT_BITWIDTH = PKT_OUT_DEF,
  parameter int unsigned SLV_NUM             = SLV_NUM_DEF
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [SLV_NUM*PACKET_IN_BITWIDTH-1:0] i_packet,
  input  logic [SLV_NUM-1:0]                    i_valid,
  output logic [SLV_NUM-1:0]                    o_ready,
  output logic [PACKET_OUT_BITWIDTH-1:0]        o_packet,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  input  logic [SLV_NUM*ID_BITWIDTH-1:0]        i_id,
  input  logic                                  i_id_valid
);

  localparam int unsigned PW = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;

  if (!widths_consistent(ID_BITWIDTH, PACKET_IN_BITWIDTH, PACKET_OUT_BITWIDTH)) begin : g_width_check
    $error("gon_bus: PACKET_OUT_BITWIDTH must equal ID_BITWIDTH + PACKET_IN_BITWIDTH");
  end

  logic [SLV_NUM*ID_BITWIDTH-1:0]   id_q;
  logic                             cfg_done_q;
  logic [PACKET_OUT_BITWIDTH-1:0]   out_q;
  logic                             out_valid_q;
  logic [PW-1:0]                    rr_ptr_q;

  logic [SLV_NUM-1:0]               grant;
  logic [PW-1:0]                    g_idx;
  logic                             g_any;
  logic                             can_load;
  logic                             xfer;
  logic [PACKET_IN_BITWIDTH-1:0]    sel_payload;
  logic [ID_BITWIDTH-1:0]           sel_tag;

  rr_arbiter #(
    .N  (SLV_NUM),
    .PW (PW)
  ) u_arb (
    .req   (i_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (g_idx),
    .any   (g_any)
  );

  assign can_load = !out_valid_q || i_ready;
  // The grant winner is always valid, so any grant under cfg_done/can_load is a transfer.
  assign xfer     = cfg_done_q && can_load && g_any;
  assign o_ready  = xfer ? grant : '0;
  assign o_packet = out_q;
  assign o_valid  = out_valid_q;

  always_comb begin
    sel_payload = '0;
    sel_tag     = '0;
    for (int unsigned k = 0; k < SLV_NUM; k++) begin
      if (g_idx == PW'(k)) begin
        sel_payload = i_packet[slice_lo(k, PACKET_IN_BITWIDTH) +: PACKET_IN_BITWIDTH];
        sel_tag     = id_q[slice_lo(k, ID_BITWIDTH) +: ID_BITWIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      id_q        <= '0;
      cfg_done_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      if (i_id_valid) begin
        id_q       <= i_id;
        cfg_done_q <= 1'b1;
      end
      if (xfer) begin
        out_q       <= {sel_tag, sel_payload};
        out_valid_q <= 1'b1;
        rr_ptr_q    <= (g_idx == PW'(SLV_NUM - 1)) ? '0 : g_idx + 1'b1;
      end else if (i_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gon_bus.sv
// Directed self-checking bench for gon_bus with hand-computed expectations.
module tb_gon_bus;

  logic        i_clk;
  logic        i_rst;
  logic [47:0] i_packet;
  logic [5:0]  i_valid;
  logic [5:0]  o_ready;
  logic [11:0] o_packet;
  logic        o_valid;
  logic        i_ready;
  logic [23:0] i_id;
  logic        i_id_valid;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [23:0] IDS_A = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam logic [23:0] IDS_B = {4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  gon_bus #(
    .ID_BITWIDTH         (4),
    .PACKET_IN_BITWIDTH  (8),
    .PACKET_OUT_BITWIDTH (12),
    .SLV_NUM             (6)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_packet   (i_packet),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_packet   (o_packet),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .i_id       (i_id),
    .i_id_valid (i_id_valid)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ids(input logic [23:0] ids);
    @(negedge i_clk);
    i_id       = ids;
    i_id_valid = 1'b1;
    @(negedge i_clk);
    i_id_valid = 1'b0;
  endtask

  initial begin
    logic [11:0] held;
    i_rst      = 1'b0;
    i_packet   = '0;
    i_valid    = '0;
    i_ready    = 1'b1;
    i_id       = '0;
    i_id_valid = 1'b0;

    // Reset state
    #1;
    chk("rst_o_valid",  32'(o_valid),  32'(1'b0));
    chk("rst_o_packet", 32'(o_packet), 32'(12'h000));
    chk("rst_o_ready",  32'(o_ready),  32'(6'b000000));
    @(negedge i_clk);
    i_rst = 1'b1;

    // No grants before ID configuration
    i_valid = 6'b111111;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      #1;
      chk("nocfg_o_ready", 32'(o_ready), 32'(6'b000000));
      chk("nocfg_o_valid", 32'(o_valid), 32'(1'b0));
    end
    i_valid = '0;

    // Single transfer from slave 2
    load_ids(IDS_A);
    i_valid          = 6'b000100;
    i_packet[16 +: 8] = 8'h11;
    #1;
    chk("s2_o_ready", 32'(o_ready), 32'(6'b000100));
    @(negedge i_clk);
    chk("s2_o_packet", 32'(o_packet), 32'(12'h211));
    chk("s2_o_valid",  32'(o_valid),  32'(1'b1));
    i_valid = '0;

    // Fresh reset, then all slaves valid: strict round-robin with no bubbles
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    load_ids(IDS_A);
    for (int k = 0; k < 6; k++) i_packet[k*8 +: 8] = 8'hA0 + 8'(k);
    i_valid = 6'b111111;
    i_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      chk("rr_o_packet", 32'(o_packet), 32'({4'(c % 6), 8'(8'hA0 + 8'(c % 6))}));
      chk("rr_o_valid",  32'(o_valid),  32'(1'b1));
    end

    // Backpressure: output holds, no slave is readied
    held    = 12'h5A5;
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      chk("bp_o_packet", 32'(o_packet), 32'(held));
      chk("bp_o_valid",  32'(o_valid),  32'(1'b1));
      chk("bp_o_ready",  32'(o_ready),  32'(6'b000000));
    end
    i_ready = 1'b1;
    #1;
    chk("bp_release_o_ready", 32'(o_ready), 32'(6'b000001));
    @(negedge i_clk);
    chk("bp_release_o_packet", 32'(o_packet), 32'(12'h0A0));
    i_valid = '0;
    @(negedge i_clk);
    chk("drain_o_valid", 32'(o_valid), 32'(1'b0));

    // ID reload in the same cycle as a slave-3 transfer
    i_valid           = 6'b001000;
    i_packet[24 +: 8] = 8'h3C;
    i_id              = IDS_B;
    i_id_valid        = 1'b1;
    #1;
    chk("idupd_o_ready", 32'(o_ready), 32'(6'b001000));
    @(negedge i_clk);
    chk("idupd_old_tag", 32'(o_packet), 32'(12'h33C));
    i_id_valid        = 1'b0;
    i_packet[24 +: 8] = 8'h3D;
    @(negedge i_clk);
    chk("idupd_new_tag", 32'(o_packet), 32'(12'hC3D));
    i_valid = '0;
    i_ready = 1'b0;

    // Asynchronous reset while o_valid is held high
    #1;
    chk("pre_arst_o_valid", 32'(o_valid), 32'(1'b1));
    #2;
    i_rst = 1'b0;
    #1;
    chk("arst_o_valid",  32'(o_valid),  32'(1'b0));
    chk("arst_o_packet", 32'(o_packet), 32'(12'h000));
    chk("arst_o_ready",  32'(o_ready),  32'(6'b000000));
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_valid = 6'b111111;
    i_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("postrst_o_ready", 32'(o_ready), 32'(6'b000000));
      @(negedge i_clk);
    end
    i_id       = IDS_A;
    i_id_valid = 1'b1;
    #1;
    chk("reload_cycle_o_ready", 32'(o_ready), 32'(6'b000000));
    @(negedge i_clk);
    i_id_valid = 1'b0;
    #1;
    chk("postrst_ptr0_o_ready", 32'(o_ready), 32'(6'b000001));
    @(negedge i_clk);
    chk("postrst_o_packet", 32'(o_packet), 32'(12'h0A0));
    i_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gon_bus.md
# gon_bus

Global output network bus: gathers packets from SLV_NUM producer slaves (one PE row or cluster column) onto a single master link toward the global buffer. It is the return-direction counterpart of the global input multicast bus. Each forwarded packet is tagged with the configured ID of the slave that produced it. Arbitration is round-robin across requesting slaves, and a one-entry output register gives one cycle of latency at full throughput.

## Interface
- ID_BITWIDTH, 4: width of one slave ID / tag.
- PACKET_IN_BITWIDTH, 8: payload width from each slave.
- PACKET_OUT_BITWIDTH, 12: master packet width; must equal ID_BITWIDTH + PACKET_IN_BITWIDTH.
- SLV_NUM, 6: number of slave ports (≥2).
- i_clk, input, 1: clock; all state updates on rising edge.
- i_rst, input, 1: reset, asynchronous, active-low.
- i_packet, input, SLV_NUM*PACKET_IN_BITWIDTH: slave payloads; slave k occupies bits [k*PIN +: PIN].
- i_valid, input, SLV_NUM: per-slave valid.
- o_ready, output, SLV_NUM: per-slave ready; one-hot or zero.
- o_packet, output, PACKET_OUT_BITWIDTH: {tag, payload} to master.
- o_valid, output, 1: master packet valid.
- i_ready, input, 1: master ready.
- i_id, input, SLV_NUM*ID_BITWIDTH: slave ID table; slave k at [k*IDW +: IDW].
- i_id_valid, input, 1: loads i_id into the ID table.

## Operation
- ID table: SLV_NUM registers, reset to 0. Loaded from i_id on any cycle with i_id_valid=1. A cfg_done flag resets to 0 and is set by the first i_id_valid; it stays set until reset.
- No slave is granted while cfg_done=0: o_ready=0, and slave valids are ignored.
- can_load = !o_valid_q || i_ready.
- Grant: round-robin over i_valid, starting at pointer rr_ptr. The first valid slave at index (rr_ptr + j) mod SLV_NUM, for j = 0..SLV_NUM-1, wins.
- o_ready[g] = cfg_done && can_load && i_valid[g] for the winner g; all other bits are 0. o_ready is combinational from i_valid, i_ready and state.
- Transfer from slave g happens when i_valid[g] && o_ready[g]. On that edge:
  - output register ← {id_table[g], payload_g};
  - o_valid_q ← 1;
  - rr_ptr ← (g+1) mod SLV_NUM, wrapping SLV_NUM-1 → 0.
- If can_load holds and no slave transfers: o_valid_q ← 0 when i_ready=1 (register drained); otherwise hold.
- Tag uses the ID table value before the edge. A same-cycle i_id_valid affects only later transfers.
- Slaves must hold i_valid and payload stable until accepted. The bus never drops or duplicates a packet.

## Timing
- Reset values:
  - o_valid=0, o_packet=0, o_ready=0;
  - rr_ptr=0, cfg_done=0, ID table all 0.
- Latency: slave handshake at edge N → o_valid=1 with the packet after edge N.
- Throughput: one packet per cycle while i_ready=1 (pass-through ready, no bubble).
- Backpressure: with o_valid=1 and i_ready=0, o_packet/o_valid hold and o_ready=0.
- Fairness: with all slaves continuously valid, grants go 0,1,…,SLV_NUM-1,0,… Any requester waits at most SLV_NUM-1 grants.
- Simultaneous master drain and slave load in one cycle: the new packet replaces the old one, and o_valid stays 1.
- Asynchronous reset mid-transfer clears the output register. The packet is lost upstream of the master, and slaves re-present after reset. cfg_done clears, so software must reload IDs.

## Structure
- Shared package (extend the network package used by the input bus): default widths, the PACKET_OUT = ID + PACKET_IN consistency check, and a function extracting slave k's slice.
- Sub-module rr_arbiter (SLV_NUM requests, pointer in, one-hot grant plus encoded index out). Pointer update stays in gon_bus.
- Rest of gon_bus: ID table, cfg_done flag, output register and ready logic.

## Test plan
- Reset, then i_valid=6'b111111 without ID config → o_ready=0 and o_valid=0 for 10 cycles.
- Load IDs {5,4,3,2,1,0}. Slave 2 sends 8'h11 with i_ready=1 → o_ready=6'b000100 that cycle; next cycle o_packet=12'h211, o_valid=1.
- Load IDs {5,4,3,2,1,0}. All six slaves valid with payload 8'hA0+k, i_ready=1 for 12 cycles → output tags 0,1,2,3,4,5,0,… in consecutive cycles, no bubbles.
- Hold i_ready=0 for 5 cycles after the first packet → o_packet stable and o_ready=0 throughout. Raise i_ready → the next packet appears the following cycle.
- Load new i_id in the same cycle as slave 3 transfers 8'h3C → that packet carries the old tag; the next slave-3 packet carries the new tag.
- Assert i_rst=0 asynchronously while o_valid=1 → o_valid drops immediately (before the next edge) and rr_ptr returns to 0. After reset, o_ready stays 0 until IDs are reloaded.
